// File: rtl/bus_arb.sv
// Two-requester bus arbiter: per-port pending/holding registers, round-robin
// grant onto a single target bus, and an idle timeout that forces an error reply.
module bus_arb #(
  parameter int unsigned TIMEOUT = 1048575
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0addr,
  input  logic [31:0] m0wdata,
  input  logic        m0wr,
  input  logic [3:0]  m0wstrb,
  input  logic        m0req,
  output logic [31:0] m0rdata,
  output logic        m0ack,
  output logic        m0err,
  input  logic [31:0] m1addr,
  input  logic [31:0] m1wdata,
  input  logic        m1wr,
  input  logic [3:0]  m1wstrb,
  input  logic        m1req,
  output logic [31:0] m1rdata,
  output logic        m1ack,
  output logic        m1err,
  output logic [31:0] outaddr,
  output logic [31:0] outwdata,
  output logic [3:0]  outwstrb,
  output logic        outwr,
  output logic        outreq,
  input  logic [31:0] outrdata,
  input  logic        outack,
  input  logic        outerr
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wr;
  } cmd_t;

  cmd_t           in_cmd [2];
  logic [1:0]     req;

  state_e         state_q, state_d;
  logic [1:0]     pend_q, pend_d;
  logic [1:0]     load, clr;
  cmd_t           hold_q [2];
  logic           last_q, last_d;
  logic           gnt_q, gnt_d;
  logic           sel;
  logic           done;
  logic [TW-1:0]  timer_q, timer_d;
  logic           outreq_q, outreq_d;
  cmd_t           out_q, out_d;
  logic [1:0]     ack_q, ack_d;
  logic [1:0]     err_q, err_d;
  logic [1:0][31:0] rdata_q, rdata_d;

  assign in_cmd[0] = '{addr: m0addr, wdata: m0wdata, wstrb: m0wstrb, wr: m0wr};
  assign in_cmd[1] = '{addr: m1addr, wdata: m1wdata, wstrb: m1wstrb, wr: m1wr};
  assign req       = {m1req, m0req};

  // NOTE: every signal driven here gets a default first; a branch that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    out_d    = out_q;
    outreq_d = 1'b0;
    ack_d    = 2'b00;
    err_d    = 2'b00;
    rdata_d  = rdata_q;
    sel      = 1'b0;
    done     = 1'b0;
    clr      = 2'b00;
    load     = 2'b00;
    pend_d   = pend_q;

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          // Both waiting: the port that did not complete last goes first.
          sel      = (&pend_q) ? ~last_q : pend_q[1];
          gnt_d    = sel;
          out_d    = hold_q[sel];
          outreq_d = 1'b1;
          timer_d  = TW'(TIMEOUT);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (outack) begin
          done            = 1'b1;
          ack_d[gnt_q]    = 1'b1;
          err_d[gnt_q]    = outerr;
          rdata_d[gnt_q]  = outrdata;
        end else if (timer_q == '0) begin
          done            = 1'b1;
          ack_d[gnt_q]    = 1'b1;
          err_d[gnt_q]    = 1'b1;
          rdata_d[gnt_q]  = 32'h0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
        if (done) begin
          clr[gnt_q] = 1'b1;
          last_d     = gnt_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request on the completing cycle re-arms the port instead of being lost.
    for (int n = 0; n < 2; n++) begin
      load[n]   = req[n] && (!pend_q[n] || clr[n]);
      pend_d[n] = load[n] || (pend_q[n] && !clr[n]);
    end
  end

  // NOTE: holding registers carry no reset; they are only ever read behind a
  // set pending flag, which is itself reset.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (load[n]) hold_q[n] <= in_cmd[n];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= 2'b00;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      timer_q  <= '0;
      outreq_q <= 1'b0;
      out_q    <= '0;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      timer_q  <= timer_d;
      outreq_q <= outreq_d;
      out_q    <= out_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign outreq   = outreq_q;
  assign outaddr  = out_q.addr;
  assign outwdata = out_q.wdata;
  assign outwstrb = out_q.wstrb;
  assign outwr    = out_q.wr;
  assign m0ack    = ack_q[0];
  assign m1ack    = ack_q[1];
  assign m0err    = err_q[0];
  assign m1err    = err_q[1];
  assign m0rdata  = rdata_q[0];
  assign m1rdata  = rdata_q[1];

endmodule

// File: tb/tb_bus_arb.sv
// Scoreboard bench for bus_arb: directed requests push expected target commands
// and requester replies; a negedge monitor pops and compares them as they appear.
module tb_bus_arb;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0addr, m0wdata, m1addr, m1wdata;
  logic        m0wr, m1wr, m0req, m1req;
  logic [3:0]  m0wstrb, m1wstrb;
  logic [31:0] m0rdata, m1rdata;
  logic        m0ack, m1ack, m0err, m1err;
  logic [31:0] outaddr, outwdata, outrdata;
  logic [3:0]  outwstrb;
  logic        outwr, outreq, outack, outerr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wr;
    int          at;     // expected outreq cycle, -1 = not checked
  } cmd_t;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          lat;    // cycles from outreq to requester ack
  } ack_t;

  typedef struct {
    int          delay;  // cycles from outreq to outack
    logic [31:0] rdata;
    logic        err;
  } reply_t;

  cmd_t   exp_cmd_q [$];
  ack_t   exp_ack_q [$];
  reply_t reply_q   [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bus_arb #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .m0addr(m0addr), .m0wdata(m0wdata), .m0wr(m0wr), .m0wstrb(m0wstrb), .m0req(m0req),
    .m0rdata(m0rdata), .m0ack(m0ack), .m0err(m0err),
    .m1addr(m1addr), .m1wdata(m1wdata), .m1wr(m1wr), .m1wstrb(m1wstrb), .m1req(m1req),
    .m1rdata(m1rdata), .m1ack(m1ack), .m1err(m1err),
    .outaddr(outaddr), .outwdata(outwdata), .outwstrb(outwstrb), .outwr(outwr),
    .outreq(outreq), .outrdata(outrdata), .outack(outack), .outerr(outerr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Target model: answers each outreq after the planned delay.
  initial begin
    reply_t r;
    outack = 1'b0; outerr = 1'b0; outrdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && outreq && reply_q.size() > 0) begin
        r = reply_q.pop_front();
        repeat (r.delay) @(posedge clk);
        #1;
        outack = 1'b1; outerr = r.err; outrdata = r.rdata;
        @(posedge clk);
        #1;
        outack = 1'b0; outerr = 1'b0; outrdata = 32'h0;
      end
    end
  end

  // Monitor / scoreboard
  cmd_t        held;
  logic [31:0] exp_rd [2];
  int          outreq_cyc = 0;

  always @(negedge clk) begin : monitor
    cmd_t c;
    ack_t a;
    logic ack, err;
    logic [31:0] rd;
    if (rst) begin
      held      = '{addr: 32'h0, wdata: 32'h0, wstrb: 4'h0, wr: 1'b0, at: -1};
      exp_rd[0] = 32'h0;
      exp_rd[1] = 32'h0;
    end else begin
      if (outreq) begin
        if (exp_cmd_q.size() == 0) begin
          check("unexpected_outreq", 32'(outreq), 32'h0);
        end else begin
          c = exp_cmd_q.pop_front();
          check("outaddr",  outaddr,  c.addr);
          check("outwdata", outwdata, c.wdata);
          check("outwstrb", 32'(outwstrb), 32'(c.wstrb));
          check("outwr",    32'(outwr),    32'(c.wr));
          if (c.at >= 0) check("outreq_cycle", 32'(cyc), 32'(c.at));
          held       = c;
          outreq_cyc = cyc;
        end
      end else begin
        check("outaddr_hold",  outaddr, held.addr);
        check("outwstrb_hold", 32'(outwstrb), 32'(held.wstrb));
        check("outwr_hold",    32'(outwr), 32'(held.wr));
      end
      check("dual_ack", 32'(m0ack & m1ack), 32'h0);
      for (int p = 0; p < 2; p++) begin
        ack = (p == 0) ? m0ack : m1ack;
        err = (p == 0) ? m0err : m1err;
        rd  = (p == 0) ? m0rdata : m1rdata;
        if (ack) begin
          if (exp_ack_q.size() == 0) begin
            check("unexpected_ack", 32'(ack), 32'h0);
          end else begin
            a = exp_ack_q.pop_front();
            check("ack_port",    32'(p), 32'(a.port));
            check("ack_err",     32'(err), 32'(a.err));
            check("ack_rdata",   rd, a.rdata);
            check("ack_latency", 32'(cyc - outreq_cyc), 32'(a.lat));
            exp_rd[p] = a.rdata;
          end
        end else begin
          check("err_without_ack", 32'(err), 32'h0);
          check("rdata_hold", rd, exp_rd[p]);
        end
      end
    end
  end

  task automatic send(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic wr);
    if (p == 0) begin
      m0addr = addr; m0wdata = wdata; m0wstrb = wstrb; m0wr = wr; m0req = 1'b1;
    end else begin
      m1addr = addr; m1wdata = wdata; m1wstrb = wstrb; m1wr = wr; m1req = 1'b1;
    end
  endtask

  task automatic clear_reqs();
    m0req = 1'b0; m1req = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while ((exp_cmd_q.size() != 0 || exp_ack_q.size() != 0) && i < 100) begin
      @(posedge clk);
      i++;
    end
    check("drain_outstanding", 32'(exp_cmd_q.size() + exp_ack_q.size()), 32'h0);
    exp_cmd_q.delete();
    exp_ack_q.delete();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outreq"},   32'(outreq), 32'h0);
    check({tag, "_outwr"},    32'(outwr), 32'h0);
    check({tag, "_outaddr"},  outaddr, 32'h0);
    check({tag, "_outwdata"}, outwdata, 32'h0);
    check({tag, "_outwstrb"}, 32'(outwstrb), 32'h0);
    check({tag, "_m0ack"},    32'(m0ack), 32'h0);
    check({tag, "_m1ack"},    32'(m1ack), 32'h0);
    check({tag, "_m0err"},    32'(m0err), 32'h0);
    check({tag, "_m1err"},    32'(m1err), 32'h0);
    check({tag, "_m0rdata"},  m0rdata, 32'h0);
    check({tag, "_m1rdata"},  m1rdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    m0addr = 32'h0; m0wdata = 32'h0; m0wstrb = 4'h0; m0wr = 1'b0; m0req = 1'b0;
    m1addr = 32'h0; m1wdata = 32'h0; m1wstrb = 4'h0; m1wr = 1'b0; m1req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single read, target answers 3 cycles after outreq.
    reply_q.push_back('{delay: 3, rdata: 32'hDEADBEEF, err: 1'b0});
    exp_cmd_q.push_back('{addr: 32'h1000, wdata: 32'h0, wstrb: 4'hF, wr: 1'b0, at: cyc + 2});
    exp_ack_q.push_back('{port: 0, err: 1'b0, rdata: 32'hDEADBEEF, lat: 4});
    send(0, 32'h1000, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1; clear_reqs();
    drain();

    // Fresh reset so arbitration restarts with port 0 favoured.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Simultaneous writes: port 0 first, port 1 granted the cycle after port 0's ack.
    reply_q.push_back('{delay: 1, rdata: 32'h0, err: 1'b0});
    reply_q.push_back('{delay: 1, rdata: 32'h0, err: 1'b0});
    exp_cmd_q.push_back('{addr: 32'h10, wdata: 32'hAAAA0000, wstrb: 4'hF, wr: 1'b1, at: cyc + 2});
    exp_cmd_q.push_back('{addr: 32'h20, wdata: 32'hBBBB0000, wstrb: 4'h3, wr: 1'b1, at: cyc + 5});
    exp_ack_q.push_back('{port: 0, err: 1'b0, rdata: 32'h0, lat: 2});
    exp_ack_q.push_back('{port: 1, err: 1'b0, rdata: 32'h0, lat: 2});
    send(0, 32'h10, 32'hAAAA0000, 4'hF, 1'b1);
    send(1, 32'h20, 32'hBBBB0000, 4'h3, 1'b1);
    @(posedge clk); #1; clear_reqs();
    drain();

    // Target error on a partial-strobe write from port 0.
    reply_q.push_back('{delay: 2, rdata: 32'h0, err: 1'b1});
    exp_cmd_q.push_back('{addr: 32'h40, wdata: 32'h12345678, wstrb: 4'hC, wr: 1'b1, at: cyc + 2});
    exp_ack_q.push_back('{port: 0, err: 1'b1, rdata: 32'h0, lat: 3});
    send(0, 32'h40, 32'h12345678, 4'hC, 1'b1);
    @(posedge clk); #1; clear_reqs();
    drain();

    // Port 0 completed last, so the next simultaneous pair goes to port 1 first.
    reply_q.push_back('{delay: 2, rdata: 32'h11111111, err: 1'b0});
    reply_q.push_back('{delay: 1, rdata: 32'h22222222, err: 1'b0});
    exp_cmd_q.push_back('{addr: 32'h50, wdata: 32'h0, wstrb: 4'hF, wr: 1'b0, at: cyc + 2});
    exp_cmd_q.push_back('{addr: 32'h30, wdata: 32'h0, wstrb: 4'hF, wr: 1'b0, at: cyc + 6});
    exp_ack_q.push_back('{port: 1, err: 1'b0, rdata: 32'h11111111, lat: 3});
    exp_ack_q.push_back('{port: 0, err: 1'b0, rdata: 32'h22222222, lat: 2});
    send(0, 32'h30, 32'h0, 4'hF, 1'b0);
    send(1, 32'h50, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1; clear_reqs();
    drain();

    // Timeout: target answers only after the limit; that late reply must be ignored.
    reply_q.push_back('{delay: T + 4, rdata: 32'hCAFEF00D, err: 1'b0});
    exp_cmd_q.push_back('{addr: 32'h2000, wdata: 32'h0, wstrb: 4'hF, wr: 1'b0, at: cyc + 2});
    exp_ack_q.push_back('{port: 1, err: 1'b1, rdata: 32'h0, lat: T + 1});
    send(1, 32'h2000, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1; clear_reqs();
    drain();

    // Re-request from port 0 in the very cycle its ack is high.
    reply_q.push_back('{delay: 2, rdata: 32'hA5A5A5A5, err: 1'b0});
    exp_cmd_q.push_back('{addr: 32'h3000, wdata: 32'h0, wstrb: 4'hF, wr: 1'b0, at: cyc + 2});
    exp_ack_q.push_back('{port: 0, err: 1'b0, rdata: 32'hA5A5A5A5, lat: 3});
    send(0, 32'h3000, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1; clear_reqs();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m0ack) begin
        seen = 1'b1;
        break;
      end
    end
    check("m0ack_seen", 32'(seen), 32'h1);
    if (seen) begin
      reply_q.push_back('{delay: 1, rdata: 32'h5A5A5A5A, err: 1'b0});
      exp_cmd_q.push_back('{addr: 32'h3004, wdata: 32'h0, wstrb: 4'hF, wr: 1'b0, at: cyc + 2});
      exp_ack_q.push_back('{port: 0, err: 1'b0, rdata: 32'h5A5A5A5A, lat: 2});
      send(0, 32'h3004, 32'h0, 4'hF, 1'b0);
      @(posedge clk); #1; clear_reqs();
    end
    drain();

    // Reset while BUSY: no ack, outputs return to reset values, target reply lands in IDLE.
    reply_q.push_back('{delay: 8, rdata: 32'hFFFFFFFF, err: 1'b1});
    exp_cmd_q.push_back('{addr: 32'h4000, wdata: 32'h77777777, wstrb: 4'h5, wr: 1'b1, at: cyc + 2});
    send(1, 32'h4000, 32'h77777777, 4'h5, 1'b1);
    @(posedge clk); #1; clear_reqs();
    repeat (4) @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("busy_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (7) @(posedge clk); #1;

    reply_q.push_back('{delay: 2, rdata: 32'h0BADF00D, err: 1'b0});
    exp_cmd_q.push_back('{addr: 32'h5000, wdata: 32'h0, wstrb: 4'hF, wr: 1'b0, at: cyc + 2});
    exp_ack_q.push_back('{port: 0, err: 1'b0, rdata: 32'h0BADF00D, lat: 3});
    send(0, 32'h5000, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1; clear_reqs();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 Parameter TIMEOUT, default 1048575, target-idle cycle limit per transaction before a forced error reply.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 m0addr/m1addr  input  32  requester byte address.
REQ-005 m0wdata/m1wdata  input  32  requester write data.
REQ-006 m0wr/m1wr  input  1  1 = write, 0 = read.
REQ-007 m0wstrb/m1wstrb  input  4  requester byte enables.
REQ-008 m0req/m1req  input  1  single-cycle request pulse; fields above valid in the same cycle.
REQ-009 m0rdata/m1rdata  output  32  read data returned to requester.
REQ-010 m0ack/m1ack  output  1  single-cycle completion pulse.
REQ-011 m0err/m1err  output  1  error flag, valid with ack.
REQ-012 outaddr, outwdata, outwstrb, outwr  output  32/32/4/1  target bus command fields.
REQ-013 outreq  output  1  single-cycle target request pulse.
REQ-014 outrdata  input  32; outack  input  1; outerr  input  1  target reply, outerr/outrdata valid when outack high.

Function
REQ-015 Each port SHALL have a pending flag plus holding registers (addr, wdata, wr, wstrb), loaded on the edge where mNreq is high.
REQ-016 mNreq while port N pending SHALL be ignored; holding registers unchanged.
REQ-017 mNreq in the same cycle as the ack completing port N SHALL be latched (new pending wins over clear).
REQ-018 State machine: IDLE, BUSY.
REQ-019 IDLE, no pending: stay IDLE, outreq 0.
REQ-020 IDLE, one port pending: grant it; outreq 1 for one cycle with that port's held fields; timer = TIMEOUT; go BUSY.
REQ-021 IDLE, both pending: grant the port not granted last (round-robin); after reset, port 0 wins first.
REQ-022 Latency: mNreq high in cycle c -> pending in c+1 -> outreq high in c+2 (no bypass).
REQ-023 Out fields SHALL hold the granted values from outreq until the next grant.
REQ-024 BUSY: timer decrements each cycle; outack high -> granted mNack = 1, mNerr = outerr, mNrdata = outrdata for one cycle; clear pending; record last-granted; go IDLE.
REQ-025 BUSY, timer == 0 and outack low: mNack = 1, mNerr = 1, mNrdata = 0; clear pending; record last-granted; go IDLE.
REQ-026 outack in IDLE (late reply after timeout) SHALL be ignored.
REQ-027 Ack for port N SHALL never coincide with ack for the other port; m(N)ack/err deasserted every cycle not selected by REQ-024/025.
REQ-028 mNrdata SHALL hold its last value between acks.
REQ-029 Back-to-back: earliest next outreq is the cycle after the completing ack (BUSY -> IDLE -> grant).

Reset
REQ-030 On rst high, immediately: state IDLE; both pending 0; last-granted = port 1; timer 0.
REQ-031 Outputs at reset: outreq 0, outwr 0, outaddr 0, outwdata 0, outwstrb 0, m0ack/m1ack 0, m0err/m1err 0, m0rdata/m1rdata 0.
REQ-032 Reset mid-transaction SHALL drop the outstanding transfer with no ack; target replies arriving after deassertion fall under REQ-026.

Verification
REQ-033 Single read: m0req, m0addr 0x1000, m0wr 0; target acks 3 cycles after outreq with outrdata 0xDEADBEEF -> outaddr 0x1000 at c+2, m0ack 1 cycle with m0rdata 0xDEADBEEF, m0err 0.
REQ-034 Simultaneous: m0req and m1req same cycle, writes to 0x10/0x20 -> outaddr 0x10 first, 0x20 next; subsequent simultaneous pair -> port 1 first.
REQ-035 Timeout: TIMEOUT = 15, target never acks -> m1ack with m1err 1, m1rdata 0, exactly TIMEOUT+1 cycles after outreq; late outack then ignored.
REQ-036 Error: target acks with outerr 1 on write wstrb 0xC -> outwstrb 0xC, m0ack with m0err 1.
REQ-037 Re-request on ack cycle: m0req asserted in the cycle m0ack is high -> new request issued, no loss.
REQ-038 Reset in BUSY: rst pulsed mid-transfer -> no ack, all outputs at REQ-031 values, next request served normally.
